// File: rtl/lgv8_pkg.sv
// Shared LEGv8 core constants, ALU codes and ID/EX bundle types.
package lgv8_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 6;
  localparam int unsigned ALUOP_W = 4;

  localparam logic [REG_W-1:0] XZR_IDX = 5'd31;

  localparam logic [ALUOP_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_ORR   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_LSL   = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_LSR   = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_PASSB = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALU_MOVZ  = 4'b1000;

  // Everything that must read as zero in a bubble lives here.
  typedef struct packed {
    logic               valid;
    logic [ALUOP_W-1:0] aluctrl;
    logic               r_type;
    logic               shamt_ins;
    logic               imm;
    logic               iw_type;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               branch;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  reg_out1;
    logic [DATA_W-1:0]  reg_out2;
    logic [DATA_W-1:0]  ext_out;
    logic [DATA_W-1:0]  mov_shamt;
    logic [SHAMT_W-1:0] shamt;
    logic [REG_W-1:0]   rn;
    logic [REG_W-1:0]   rm;
    logic [REG_W-1:0]   rd;
  } data_t;

  function automatic logic is_xzr(input logic [REG_W-1:0] idx);
    return idx == XZR_IDX;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-to-EX bus: decoded operands and control from ID, registered copies toward EX.
interface id_ex_pipe_reg_if;
  import lgv8_pkg::*;

  logic               valid_ID;
  logic [DATA_W-1:0]  pc_ID;
  logic [DATA_W-1:0]  RegOut1_ID;
  logic [DATA_W-1:0]  RegOut2_ID;
  logic [DATA_W-1:0]  extender_out_ID;
  logic [DATA_W-1:0]  mov_shamt_ID;
  logic [SHAMT_W-1:0] shamt_ID;
  logic [REG_W-1:0]   rn_ID;
  logic [REG_W-1:0]   rm_ID;
  logic [REG_W-1:0]   rd_ID;
  logic [ALUOP_W-1:0] aluctrl_ID;
  logic               r_type_ID;
  logic               shamt_ins_ID;
  logic               Imm_ID;
  logic               iw_type_ID;
  logic               RegWrite_ID;
  logic               MemRead_ID;
  logic               MemWrite_ID;
  logic               MemToReg_ID;
  logic               Branch_ID;

  logic               valid_EX;
  logic [DATA_W-1:0]  pc_EX;
  logic [DATA_W-1:0]  RegOut1_EX;
  logic [DATA_W-1:0]  RegOut2_EX;
  logic [DATA_W-1:0]  extender_out_EX;
  logic [DATA_W-1:0]  mov_shamt_EX;
  logic [SHAMT_W-1:0] shamt_EX;
  logic [REG_W-1:0]   rn_EX;
  logic [REG_W-1:0]   rm_EX;
  logic [REG_W-1:0]   rd_EX;
  logic [ALUOP_W-1:0] aluctrl_EX;
  logic               r_type_EX;
  logic               shamt_ins_EX;
  logic               Imm_EX;
  logic               iw_type_EX;
  logic               RegWrite_EX;
  logic               MemRead_EX;
  logic               MemWrite_EX;
  logic               MemToReg_EX;
  logic               Branch_EX;

  modport master (
    output valid_ID, pc_ID, RegOut1_ID, RegOut2_ID, extender_out_ID, mov_shamt_ID, shamt_ID,
           rn_ID, rm_ID, rd_ID, aluctrl_ID, r_type_ID, shamt_ins_ID, Imm_ID, iw_type_ID,
           RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID, Branch_ID,
    input  valid_EX, pc_EX, RegOut1_EX, RegOut2_EX, extender_out_EX, mov_shamt_EX, shamt_EX,
           rn_EX, rm_EX, rd_EX, aluctrl_EX, r_type_EX, shamt_ins_EX, Imm_EX, iw_type_EX,
           RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, Branch_EX
  );

  modport slave (
    input  valid_ID, pc_ID, RegOut1_ID, RegOut2_ID, extender_out_ID, mov_shamt_ID, shamt_ID,
           rn_ID, rm_ID, rd_ID, aluctrl_ID, r_type_ID, shamt_ins_ID, Imm_ID, iw_type_ID,
           RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID, Branch_ID,
    output valid_EX, pc_EX, RegOut1_EX, RegOut2_EX, extender_out_EX, mov_shamt_EX, shamt_EX,
           rn_EX, rm_EX, rd_EX, aluctrl_EX, r_type_EX, shamt_ins_EX, Imm_EX, iw_type_EX,
           RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, Branch_EX
  );

endinterface

// File: rtl/pipe_field_dff.sv
// Generic pipeline field register: async reset, synchronous clear beats hold beats load.
module pipe_field_dff #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hold_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (!hold_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// LEGv8 ID/EX pipeline register with stall, flush-to-bubble and XZR write suppression.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg
  import lgv8_pkg::*;
`ifdef ID_EX_BUBBLE_CNT_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  id_ex_pipe_reg_if.slave  bus
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;

  // Invalid slots carry no side effects: control collapses to zero, data passes through.
  always_comb begin
    ctrl_d = '0;
    if (bus.valid_ID) begin
      ctrl_d.valid      = 1'b1;
      ctrl_d.aluctrl    = bus.aluctrl_ID;
      ctrl_d.r_type     = bus.r_type_ID;
      ctrl_d.shamt_ins  = bus.shamt_ins_ID;
      ctrl_d.imm        = bus.Imm_ID;
      ctrl_d.iw_type    = bus.iw_type_ID;
      ctrl_d.reg_write  = bus.RegWrite_ID & ~is_xzr(bus.rd_ID);
      ctrl_d.mem_read   = bus.MemRead_ID;
      ctrl_d.mem_write  = bus.MemWrite_ID;
      ctrl_d.mem_to_reg = bus.MemToReg_ID;
      ctrl_d.branch     = bus.Branch_ID;
    end
  end

  always_comb begin
    data_d           = '0;
    data_d.pc        = bus.pc_ID;
    data_d.reg_out1  = bus.RegOut1_ID;
    data_d.reg_out2  = bus.RegOut2_ID;
    data_d.ext_out   = bus.extender_out_ID;
    data_d.mov_shamt = bus.mov_shamt_ID;
    data_d.shamt     = bus.shamt_ID;
    data_d.rn        = bus.rn_ID;
    data_d.rm        = bus.rm_ID;
    data_d.rd        = bus.rd_ID;
  end

  pipe_field_dff #(
    .WIDTH   ($bits(ctrl_t)),
    .RST_VAL ('0)
  ) u_ctrl_ff (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hold_i (stall),
    .clr_i  (flush),
    .d_i    (ctrl_d),
    .q_o    (ctrl_q)
  );

  pipe_field_dff #(
    .WIDTH   ($bits(data_t)),
    .RST_VAL ('0)
  ) u_data_ff (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hold_i (stall),
    .clr_i  (flush),
    .d_i    (data_d),
    .q_o    (data_q)
  );

  assign bus.valid_EX        = ctrl_q.valid;
  assign bus.aluctrl_EX      = ctrl_q.aluctrl;
  assign bus.r_type_EX       = ctrl_q.r_type;
  assign bus.shamt_ins_EX    = ctrl_q.shamt_ins;
  assign bus.Imm_EX          = ctrl_q.imm;
  assign bus.iw_type_EX      = ctrl_q.iw_type;
  assign bus.RegWrite_EX     = ctrl_q.reg_write;
  assign bus.MemRead_EX      = ctrl_q.mem_read;
  assign bus.MemWrite_EX     = ctrl_q.mem_write;
  assign bus.MemToReg_EX     = ctrl_q.mem_to_reg;
  assign bus.Branch_EX       = ctrl_q.branch;

  assign bus.pc_EX           = data_q.pc;
  assign bus.RegOut1_EX      = data_q.reg_out1;
  assign bus.RegOut2_EX      = data_q.reg_out2;
  assign bus.extender_out_EX = data_q.ext_out;
  assign bus.mov_shamt_EX    = data_q.mov_shamt;
  assign bus.shamt_EX        = data_q.shamt;
  assign bus.rn_EX           = data_q.rn;
  assign bus.rm_EX           = data_q.rm;
  assign bus.rd_EX           = data_q.rd;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic             bubble_edge;

  // A flush always produces a bubble; otherwise only an unstalled invalid load does.
  assign bubble_edge = flush | (~stall & ~bus.valid_ID);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_edge && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
